compound_relay_n: RTL and testbench
===================================

# compound_relay_n

Multi-channel successor to the single-channel compound-type relay. Accepts `{mode, x, y}` packets on `NUM_CH` sync/notify input channels using a rotating one-hot grant. Keeps one shadow register per channel. Write packets update the shadow; read packets emit a combined result on a single sync/notify output. It sits between per-channel producers and one downstream consumer in the abstract-model test designs.

## Interface
Parameters:
- `NUM_CH`, default 4: number of input channels, 2..16.
- `X_WIDTH`, default 32: width of the `x` field.
- `SATURATE`, default 0: 0 means `x` addition wraps mod 2^X_WIDTH; 1 means unsigned saturation at 2^X_WIDTH-1.

Ports:
- `clk`  in  1  clock; all activity on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `b_in_mode`  in  NUM_CH  per-channel mode; 0 = read, 1 = write.
- `b_in_x`  in  NUM_CH*X_WIDTH  per-channel `x`; channel i is at `[i*X_WIDTH +: X_WIDTH]`.
- `b_in_y`  in  NUM_CH  per-channel `y` flag.
- `b_in_sync`  in  NUM_CH  producer i has a valid packet.
- `b_in_notify`  out  NUM_CH  registered one-hot grant; block is ready on that channel.
- `b_out_mode`  out  1  always 0 (read) when valid.
- `b_out_x`  out  X_WIDTH  result `x`.
- `b_out_y`  out  1  result `y`.
- `b_out_ch`  out  max(1,$clog2(NUM_CH))  source channel of the result.
- `b_out_notify`  out  1  result valid.
- `b_out_sync`  in  1  consumer accepts the result.

## Operation
- A transfer on input channel i happens in any cycle where `b_in_notify[i]` and `b_in_sync[i]` are both high. The output transfer happens when `b_out_notify` and `b_out_sync` are both high.
- State `section`, registered: `SECTION_A` (collect) and `SECTION_B` (emit). Grant pointer `ptr` runs 0..NUM_CH-1.
- In SECTION_A:
  - `b_in_notify` = one-hot(`ptr`); `b_out_notify` = 0.
  - No sync on `ptr`: `ptr` advances to `ptr+1` (wrapping to 0).
  - Write transfer: `shadow[ptr].x <= x`, `shadow[ptr].y <= y`; `ptr` advances; stay in A.
  - Read transfer: `b_out_x <= shadow[ptr].x + x` (wrap or saturate per `SATURATE`, computed at X_WIDTH+1 bits); `b_out_y <= shadow[ptr].y ^ y`; `b_out_ch <= ptr`; `b_out_mode <= 0`. Go to B. Shadow is unchanged.
- In SECTION_B:
  - `b_in_notify` = all 0; the `b_out_*` fields are held stable.
  - On output transfer: `b_out_notify` goes to 0, state goes to A, and `ptr <= b_out_ch+1` (wrap).
- `b_in_sync` on non-granted channels is ignored. Producers must hold their data until granted.
- Reset, as long as `rst` = 0 at a clock edge:
  - section = A, `ptr` = 0, `b_in_notify` = 1 on channel 0 only, `b_out_notify` = 0.
  - `b_out_mode` = 0, `b_out_x` = 0, `b_out_y` = 0, `b_out_ch` = 0.
  - All shadows `{x=0, y=0}`.
  - Reset during B discards the pending result.

## Timing
- All outputs are registered. There is no combinational path from any sync input to any notify or data output.
- Write: accepted in cycle T. At T+1, `b_in_notify` is one-hot(`ptr+1`). A read of the same channel on its next grant sees the new shadow.
- Read: accepted in cycle T. At T+1, `b_out_notify` = 1 with valid data. Minimum read-to-read period is 2 cycles.
- Output accepted in cycle U. At U+1, `b_out_notify` = 0 and `b_in_notify` = one-hot(`b_out_ch+1`).
- Idle scan: the grant visits each channel for exactly one cycle. Worst-case wait for a lone producer is NUM_CH-1 cycles.
- Saturation boundary: sum = 2^X_WIDTH-1 passes through unchanged; sum >= 2^X_WIDTH clamps to 2^X_WIDTH-1.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release. Required: `b_in_notify` = 4'b0001, `b_out_notify` = 0, all `b_out_*` = 0. With no syncs, the grant steps 0001→0010→0100→1000→0001.
- Write then read on ch2 (NUM_CH=4, X_WIDTH=8): write x=10, y=1; then read x=5, y=1. Required: one cycle later `b_out_notify` = 1, x=15, y=0, ch=2.
- Arithmetic boundary: shadow x=250, read x=10. Required with SATURATE=0: x=4. Required with SATURATE=1: x=255. A read of x=5 gives 255 in both modes.
- Backpressure: read on ch1, then hold `b_out_sync` = 0 for 5 cycles. Required: outputs stable and `b_in_notify` = 0 throughout. After `b_out_sync` is raised: the next cycle shows `b_out_notify` = 0 and `b_in_notify` = 4'b0100.
- Lone producer: only ch3 syncs from reset. Required: transfer in the 4th post-reset cycle (grant reaches ch3 then), and earlier channels are untouched.
- Reset mid-emit: assert `rst` = 0 while in B. Required: next cycle `b_out_notify` = 0, `b_in_notify` = 4'b0001, and all shadows are cleared (a following read of x=7 returns 7).

Source files
------------

// File: rtl/compound_relay_n_if.sv
// Bundle of the per-channel input handshakes and the single result handshake
// between producers, the relay and its downstream consumer.
interface compound_relay_n_if #(
  parameter int NUM_CH  = 4,
  parameter int X_WIDTH = 32
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]         b_in_mode;
  logic [NUM_CH*X_WIDTH-1:0] b_in_x;
  logic [NUM_CH-1:0]         b_in_y;
  logic [NUM_CH-1:0]         b_in_sync;
  logic [NUM_CH-1:0]         b_in_notify;
  logic                      b_out_mode;
  logic [X_WIDTH-1:0]        b_out_x;
  logic                      b_out_y;
  logic [CH_W-1:0]           b_out_ch;
  logic                      b_out_notify;
  logic                      b_out_sync;

  modport slave (
    input  b_in_mode, b_in_x, b_in_y, b_in_sync, b_out_sync,
    output b_in_notify, b_out_mode, b_out_x, b_out_y, b_out_ch, b_out_notify
  );

  modport master (
    output b_in_mode, b_in_x, b_in_y, b_in_sync, b_out_sync,
    input  b_in_notify, b_out_mode, b_out_x, b_out_y, b_out_ch, b_out_notify
  );
endinterface

// File: rtl/compound_relay_n.sv
// Multi-channel compound relay: round-robin grant over NUM_CH producers, one
// shadow {x,y} per channel, read packets emit shadow+packet on one output.
//
// state     | meaning
// SECTION_A | collect: grant rotates over channels, writes update shadow
// SECTION_B | emit: result held on b_out_* until the consumer takes it
module compound_relay_n #(
  parameter int NUM_CH   = 4,
  parameter int X_WIDTH  = 32,
  parameter bit SATURATE = 1'b0
) (
  input logic               clk,
  input logic               rst,
  compound_relay_n_if.slave bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [0:0] SECTION_A = 1'b0;
  localparam logic [0:0] SECTION_B = 1'b1;

  logic [0:0]         r_section;
  logic [CH_W-1:0]    r_ptr;
  logic [NUM_CH-1:0]  r_in_notify;
  logic [X_WIDTH-1:0] r_shadow_x [NUM_CH];
  logic [NUM_CH-1:0]  r_shadow_y;
  logic [X_WIDTH-1:0] r_out_x;
  logic               r_out_y;
  logic [CH_W-1:0]    r_out_ch;
  logic               r_out_notify;

  logic [X_WIDTH-1:0] w_sel_x;
  logic               w_sel_y;
  logic               w_sel_mode;
  logic               w_sel_sync;
  logic [X_WIDTH:0]   w_sum;
  logic [X_WIDTH-1:0] w_res;
  logic [CH_W-1:0]    w_ptr_next;
  logic [CH_W-1:0]    w_ret_next;

  function automatic logic [CH_W-1:0] f_wrap_inc(input logic [CH_W-1:0] p);
    if (p == CH_W'(NUM_CH - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [NUM_CH-1:0] f_onehot(input logic [CH_W-1:0] p);
    return NUM_CH'(1) << p;
  endfunction

  always_comb begin
    w_sel_x    = bus.b_in_x[r_ptr*X_WIDTH +: X_WIDTH];
    w_sel_y    = bus.b_in_y[r_ptr];
    w_sel_mode = bus.b_in_mode[r_ptr];
    w_sel_sync = bus.b_in_sync[r_ptr];
    // One extra bit keeps the carry so saturation can see the overflow.
    w_sum      = {1'b0, r_shadow_x[r_ptr]} + {1'b0, w_sel_x};
    w_res      = (SATURATE && w_sum[X_WIDTH]) ? '1 : w_sum[X_WIDTH-1:0];
    w_ptr_next = f_wrap_inc(r_ptr);
    w_ret_next = f_wrap_inc(r_out_ch);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_section    <= SECTION_A;
      r_ptr        <= '0;
      r_in_notify  <= f_onehot('0);
      r_shadow_y   <= '0;
      r_out_x      <= '0;
      r_out_y      <= 1'b0;
      r_out_ch     <= '0;
      r_out_notify <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_shadow_x[i] <= '0;
    end else begin
      case (r_section)
        SECTION_A: begin
          if (w_sel_sync && !w_sel_mode) begin
            r_out_x      <= w_res;
            r_out_y      <= r_shadow_y[r_ptr] ^ w_sel_y;
            r_out_ch     <= r_ptr;
            r_out_notify <= 1'b1;
            r_in_notify  <= '0;
            r_section    <= SECTION_B;
          end else begin
            if (w_sel_sync) begin
              r_shadow_x[r_ptr] <= w_sel_x;
              r_shadow_y[r_ptr] <= w_sel_y;
            end
            r_ptr       <= w_ptr_next;
            r_in_notify <= f_onehot(w_ptr_next);
          end
        end
        default: begin
          if (bus.b_out_sync) begin
            r_out_notify <= 1'b0;
            r_ptr        <= w_ret_next;
            r_in_notify  <= f_onehot(w_ret_next);
            r_section    <= SECTION_A;
          end
        end
      endcase
    end
  end

  assign bus.b_in_notify  = r_in_notify;
  assign bus.b_out_mode   = 1'b0;
  assign bus.b_out_x      = r_out_x;
  assign bus.b_out_y      = r_out_y;
  assign bus.b_out_ch     = r_out_ch;
  assign bus.b_out_notify = r_out_notify;
endmodule

// File: tb/tb_compound_relay_n.sv
// Bench for compound_relay_n: a wrapping and a saturating instance driven with
// identical stimulus, results checked against a shadow model via a scoreboard.
module tb_compound_relay_n;
  localparam int NCH = 4;
  localparam int XW  = 8;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] x0;
    logic [7:0] x1;
    logic       y;
  } exp_t;

  logic            clk = 1'b0;
  logic            t_rst;
  logic [NCH-1:0]  t_mode, t_y, t_sync;
  logic [NCH*XW-1:0] t_x;
  logic            t_out_sync;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  logic [7:0] m_x [NCH];
  logic [NCH-1:0] m_y;

  compound_relay_n_if #(.NUM_CH(NCH), .X_WIDTH(XW)) if0 ();
  compound_relay_n_if #(.NUM_CH(NCH), .X_WIDTH(XW)) if1 ();

  assign if0.b_in_mode = t_mode;  assign if1.b_in_mode = t_mode;
  assign if0.b_in_x    = t_x;     assign if1.b_in_x    = t_x;
  assign if0.b_in_y    = t_y;     assign if1.b_in_y    = t_y;
  assign if0.b_in_sync = t_sync;  assign if1.b_in_sync = t_sync;
  assign if0.b_out_sync = t_out_sync;
  assign if1.b_out_sync = t_out_sync;

  compound_relay_n #(.NUM_CH(NCH), .X_WIDTH(XW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(t_rst), .bus(if0));
  compound_relay_n #(.NUM_CH(NCH), .X_WIDTH(XW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(t_rst), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [NCH-1:0] exp_grant(input int c);
    logic [NCH-1:0] one;
    one = 1;
    return one << (c % NCH);
  endfunction

  // Starts and ends on a negedge; returns the number of cycles spent waiting for grant.
  task automatic send(input int c, input logic md, input logic [7:0] x, input logic y,
                      output int waits);
    int s;
    exp_t e;
    t_mode[c] = md;
    t_x[c*XW +: XW] = x;
    t_y[c] = y;
    t_sync[c] = 1'b1;
    waits = 0;
    while (!if0.b_in_notify[c] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    n_tests++;
    if (!if0.b_in_notify[c]) begin
      n_fail++;
      $display("FAIL grant_timeout ch%0d: notify=%b required bit %0d", c, if0.b_in_notify, c);
      t_sync[c] = 1'b0;
      return;
    end
    @(posedge clk);
    if (md) begin
      m_x[c] = x;
      m_y[c] = y;
    end else begin
      s = int'(m_x[c]) + int'(x);
      e.ch = 2'(c);
      e.x0 = 8'(s);
      e.x1 = (s > 255) ? 8'hFF : 8'(s);
      e.y  = m_y[c] ^ y;
      sb.push_back(e);
    end
    @(negedge clk);
    t_sync[c] = 1'b0;
    if (!md) begin
      n_tests++;
      if (if0.b_out_notify !== 1'b1 || if1.b_out_notify !== 1'b1) begin
        n_fail++;
        $display("FAIL read_latency ch%0d: out_notify=%b/%b required 1", c,
                 if0.b_out_notify, if1.b_out_notify);
      end
    end
  endtask

  // Accepts one result and compares it with the scoreboard head; ends on a negedge.
  task automatic recv();
    exp_t e;
    int w;
    t_out_sync = 1'b1;
    w = 0;
    while (!if0.b_out_notify && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (!if0.b_out_notify || sb.size() == 0) begin
      n_fail++;
      $display("FAIL recv_timeout: out_notify=%b queued=%0d required 1 and >0",
               if0.b_out_notify, sb.size());
      t_out_sync = 1'b0;
      return;
    end
    e = sb.pop_front();
    n_tests++;
    if (if0.b_out_x !== e.x0 || if1.b_out_x !== e.x1 || if0.b_out_y !== e.y ||
        if1.b_out_y !== e.y || if0.b_out_ch !== e.ch || if1.b_out_ch !== e.ch ||
        if0.b_out_mode !== 1'b0 || if1.b_out_notify !== 1'b1) begin
      n_fail++;
      $display("FAIL result: x=%0d/%0d y=%b/%b ch=%0d mode=%b got, required x=%0d/%0d y=%b ch=%0d mode=0",
               if0.b_out_x, if1.b_out_x, if0.b_out_y, if1.b_out_y, if0.b_out_ch,
               if0.b_out_mode, e.x0, e.x1, e.y, e.ch);
    end
    @(posedge clk);
    @(negedge clk);
    t_out_sync = 1'b0;
    n_tests++;
    if (if0.b_out_notify !== 1'b0 || if0.b_in_notify !== exp_grant(int'(e.ch) + 1)) begin
      n_fail++;
      $display("FAIL release: out_notify=%b grant=%b required 0 and %b",
               if0.b_out_notify, if0.b_in_notify, exp_grant(int'(e.ch) + 1));
    end
  endtask

  task automatic apply_reset();
    t_sync = '0;
    t_out_sync = 1'b0;
    t_rst = 1'b0;
    repeat (2) @(negedge clk);
    t_rst = 1'b1;
    m_y = '0;
    for (int i = 0; i < NCH; i++) m_x[i] = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (if0.b_in_notify !== 4'b0001 || if0.b_out_notify !== 1'b0 || if0.b_out_x !== 8'd0 ||
        if0.b_out_y !== 1'b0 || if0.b_out_ch !== 2'd0 || if0.b_out_mode !== 1'b0 ||
        if1.b_in_notify !== 4'b0001 || if1.b_out_x !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b out_notify=%b x=%0d y=%b ch=%0d",
               if0.b_in_notify, if0.b_out_notify, if0.b_out_x, if0.b_out_y, if0.b_out_ch);
    end
    for (int k = 1; k <= NCH; k++) begin
      @(negedge clk);
      n_tests++;
      if (if0.b_in_notify !== exp_grant(k)) begin
        n_fail++;
        $display("FAIL idle_scan step%0d: grant=%b required %b", k, if0.b_in_notify, exp_grant(k));
      end
    end
  endtask

  task automatic test_lone_producer();
    int w;
    apply_reset();
    send(3, 1'b1, 8'd9, 1'b1, w);
    n_tests++;
    if (w != 3) begin
      n_fail++;
      $display("FAIL lone_wait: waited %0d cycles required 3", w);
    end
    n_tests++;
    if (if0.b_in_notify !== 4'b0001) begin
      n_fail++;
      $display("FAIL lone_wrap: grant=%b required 0001", if0.b_in_notify);
    end
    for (int c = 0; c < NCH; c++) begin
      send(c, 1'b0, 8'd0, 1'b0, w);
      recv();
    end
  endtask

  task automatic test_write_read();
    int w;
    send(2, 1'b1, 8'd10, 1'b1, w);
    n_tests++;
    if (if0.b_in_notify !== 4'b1000) begin
      n_fail++;
      $display("FAIL write_advance: grant=%b required 1000", if0.b_in_notify);
    end
    send(2, 1'b0, 8'd5, 1'b1, w);
    recv();
  endtask

  task automatic test_arith_boundary();
    int w;
    send(0, 1'b1, 8'd250, 1'b0, w);
    send(0, 1'b0, 8'd10, 1'b0, w);
    recv();
    send(0, 1'b0, 8'd5, 1'b1, w);
    recv();
    send(1, 1'b1, 8'd255, 1'b0, w);
    send(1, 1'b0, 8'd1, 1'b0, w);
    recv();
  endtask

  task automatic test_backpressure();
    int w;
    send(1, 1'b1, 8'd33, 1'b0, w);
    t_out_sync = 1'b0;
    send(1, 1'b0, 8'd2, 1'b1, w);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (if0.b_out_notify !== 1'b1 || if0.b_out_x !== 8'd35 || if0.b_out_y !== 1'b1 ||
          if0.b_out_ch !== 2'd1 || if0.b_in_notify !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold cyc%0d: notify=%b x=%0d y=%b ch=%0d grant=%b required 1 35 1 1 0000",
                 k, if0.b_out_notify, if0.b_out_x, if0.b_out_y, if0.b_out_ch, if0.b_in_notify);
      end
      @(negedge clk);
    end
    recv();
  endtask

  task automatic test_back_to_back();
    int w;
    send(3, 1'b1, 8'd100, 1'b0, w);
    send(2, 1'b1, 8'd200, 1'b1, w);
    for (int k = 0; k < 3; k++) begin
      send(3, 1'b0, 8'(k * 60), 1'(k), w);
      recv();
      send(2, 1'b0, 8'(k * 30), 1'b0, w);
      recv();
    end
  endtask

  task automatic test_reset_mid_emit();
    int w;
    send(2, 1'b0, 8'd1, 1'b0, w);
    t_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if0.b_out_notify !== 1'b0 || if0.b_in_notify !== 4'b0001 || if0.b_out_x !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_emit_reset: out_notify=%b grant=%b x=%0d required 0 0001 0",
               if0.b_out_notify, if0.b_in_notify, if0.b_out_x);
    end
    t_rst = 1'b1;
    m_y = '0;
    for (int i = 0; i < NCH; i++) m_x[i] = '0;
    sb.delete();
    send(2, 1'b0, 8'd7, 1'b0, w);
    recv();
    send(0, 1'b0, 8'd7, 1'b0, w);
    recv();
  endtask

  initial begin
    t_rst = 1'b0;
    t_mode = '0;
    t_x = '0;
    t_y = '0;
    t_sync = '0;
    t_out_sync = 1'b0;
    @(negedge clk);
    test_reset();
    test_lone_producer();
    test_write_read();
    test_arith_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
